fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Control-side counterpart of the pipeline's 2:1/3:1 operand muxes: generates the 2-bit forward selects that steer the EX-stage ALU operand Mux3 instances.
- Generates load-use stall and branch-flush controls for the 5-stage RV32I pipeline.
- Keeps its own shadow pipeline (EX/MEM/WB slots) of destination info, so the datapath only feeds decode-stage fields and the EX branch-taken signal.
- Forward selects are registered at the ID→EX transition.

Parameters:
- REG_ADDR_W, 5, register index width (x0..x31).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_ADDR_W  ID source register 1.
- id_rs2  in  REG_ADDR_W  ID source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  REG_ADDR_W  ID destination.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- ex_flush  in  1  branch/jump taken, resolved in EX this cycle.
- fwd_a_sel  out  2  registered select for ALU operand A Mux3.
- fwd_b_sel  out  2  registered select for ALU operand B / store-data Mux3.
- stall_pc  out  1  hold PC (combinational).
- stall_ifid  out  1  hold IF/ID register (combinational).
- flush_ifid  out  1  clear IF/ID register (combinational).
- bubble_idex  out  1  load NOP into ID/EX (combinational).

Behaviour:
- Reset is asynchronous on rst_n low: all shadow slots invalid, fwd_a_sel = fwd_b_sel = 2'b00. Combinational outputs follow from the invalid slots: all 0 unless ex_flush is asserted.
- Select encoding matches the Mux3 operand order:
  - 00 = register-file value.
  - 01 = WB result.
  - 10 = MEM-stage ALU result.
  - 11 is never driven.
- Shadow slots S_EX, S_MEM, S_WB each hold {valid, rd, reg_write, mem_read}.
- Slot qualification:
  - A slot is a forwarding producer only if valid && reg_write && rd != 0.
  - A slot is a load-use producer only if valid && mem_read && rd != 0.
- Load-use hazard (combinational): id_valid && S_EX is a load-use producer && ((id_use_rs1 && id_rs1 == S_EX.rd) || (id_use_rs2 && id_rs2 == S_EX.rd)).
- Hazard without ex_flush:
  - stall_pc = stall_ifid = bubble_idex = 1.
  - Next S_EX is invalid; S_MEM and S_WB advance.
  - Next fwd sels are 00.
- ex_flush has priority over the hazard:
  - flush_ifid = bubble_idex = 1, stall_pc = stall_ifid = 0.
  - Next S_EX is invalid; next fwd sels are 00.
- Normal advance (every cycle otherwise):
  - S_EX takes the ID fields, valid = id_valid; S_MEM ← S_EX; S_WB ← S_MEM.
  - Next fwd_x_sel is computed per operand, using current S_EX as the future MEM and current S_MEM as the future WB:
    - 10 if the current S_EX producer matches rsX.
    - Else 01 if the current S_MEM producer matches rsX.
    - Else 00.
  - The MEM stage has priority over WB for the same register.
  - A current S_EX load is never selected for MEM forwarding, because the stall guarantees it.
- Operand not used (id_use_rsX = 0) or rsX = x0: select 00.
- Latency: fwd sels valid in the cycle the instruction occupies EX. Stall/flush controls are same-cycle.
- WB→ID same-cycle case is handled by the register file write-through and is not forwarded here.
- rst_n asserted mid-operation clears all state immediately. The first cycle after release is treated as an empty pipeline.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall_cnt and perf_flush_cnt, each CNT_W bits, reset to 0.
  - perf_stall_cnt increments on each load-use stall cycle.
  - perf_flush_cnt increments on each ex_flush cycle.
  - Both saturate at all-ones.
- When undefined: the ports and counters do not exist. Remaining behaviour is identical.

Decomposition:
- Package hazard_pkg:
  - enum fwd_sel_e with FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - struct hz_slot_t {valid, rd, reg_write, mem_read}.
  - REG_X0 constant.
- Sub-module fwd_sel_calc (combinational; rs, use_rs, mem slot, wb slot → fwd_sel_e), instantiated once per operand.

Test Plan:
- add x5 then add x6,x5,x1 back-to-back → fwd_a_sel = 10 in the second instruction's EX cycle, no stall.
- add x5; nop; sub x7,x1,x5 → fwd_b_sel = 01; with an add x5 in MEM and an add x5 in WB simultaneously → 10.
- lw x5 then add x6,x5,x2 → one cycle with stall_pc = stall_ifid = bubble_idex = 1, then fwd_a_sel = 01; the stall does not repeat.
- lw x0 then use x0, and addi x0 then use x0 → no stall, sels 00.
- ex_flush asserted in the same cycle as a load-use hazard → flush_ifid = 1, stall_pc = 0, next fwd sels 00; with HAZARD_PERF_CNT_EN, perf_flush_cnt +1 and perf_stall_cnt unchanged.
- Assert rst_n = 0 mid-stream with hazards pending → all outputs 0 asynchronously; after release, a dependent pair behaves as in the first scenario.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the forwarding/hazard control: operand select encoding and shadow-slot record.
package hazard_pkg;

  localparam int HZ_REG_W = 5;
  localparam logic [HZ_REG_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [HZ_REG_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } hz_slot_t;

  // x0 writes are architecturally discarded, so they never produce a value.
  function automatic logic is_fwd_producer(input hz_slot_t s);
    return s.valid && s.reg_write && (s.rd != REG_X0);
  endfunction

  function automatic logic is_load_producer(input hz_slot_t s);
    return s.valid && s.mem_read && (s.rd != REG_X0);
  endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Per-operand forward select: picks the youngest producer (future MEM before future WB) of rs.
module fwd_sel_calc
  import hazard_pkg::*;
(
  input  logic [HZ_REG_W-1:0] rs_i,
  input  logic                use_rs_i,
  input  hz_slot_t            mem_slot_i,
  input  hz_slot_t            wb_slot_i,
  output fwd_sel_e            sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (use_rs_i && (rs_i != REG_X0)) begin
      if (is_fwd_producer(mem_slot_i) && (mem_slot_i.rd == rs_i)) begin
        sel_o = FWD_MEM;
      end else if (is_fwd_producer(wb_slot_i) && (wb_slot_i.rd == rs_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forward selects, load-use stall and branch flush for the 5-stage RV32I pipeline.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_ifid,
  output logic                  bubble_idex
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);

  hz_slot_t ex_q, mem_q, wb_q;
  hz_slot_t ex_d, id_slot;
  fwd_sel_e fwd_a_q, fwd_b_q;
  fwd_sel_e fwd_a_d, fwd_b_d;
  fwd_sel_e calc_a, calc_b;
  logic     load_hazard;

  assign id_slot = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

  assign load_hazard = id_valid && is_load_producer(ex_q) &&
                       ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_q.rd)));

  // A taken branch squashes the dependent instruction, so the stall is moot.
  assign stall_pc    = load_hazard && !ex_flush;
  assign stall_ifid  = load_hazard && !ex_flush;
  assign flush_ifid  = ex_flush;
  assign bubble_idex = load_hazard || ex_flush;

  // Current EX becomes MEM and current MEM becomes WB when ID reaches EX.
  fwd_sel_calc u_fwd_a (
    .rs_i       (id_rs1),
    .use_rs_i   (id_use_rs1),
    .mem_slot_i (ex_q),
    .wb_slot_i  (mem_q),
    .sel_o      (calc_a)
  );

  fwd_sel_calc u_fwd_b (
    .rs_i       (id_rs2),
    .use_rs_i   (id_use_rs2),
    .mem_slot_i (ex_q),
    .wb_slot_i  (mem_q),
    .sel_o      (calc_b)
  );

  always_comb begin
    ex_d    = id_slot;
    fwd_a_d = calc_a;
    fwd_b_d = calc_b;
    if (bubble_idex) begin
      ex_d    = '0;
      fwd_a_d = FWD_REG;
      fwd_b_d = FWD_REG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_pc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (ex_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table, reset corner cases, randomized run vs. instruction-level model.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, ex_flush = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_pc, stall_ifid, flush_ifid, bubble_idex;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .ex_flush     (ex_flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .flush_ifid   (flush_ifid),
    .bubble_idex  (bubble_idex)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  typedef struct {
    bit       v;
    bit [4:0] rs1, rs2;
    bit       u1, u2;
    bit [4:0] rd;
    bit       rw, mr, fl;
  } in_t;

  // ctl = {stall_pc, stall_ifid, flush_ifid, bubble_idex}; a/b are the selects seen in the next cycle
  typedef struct {
    bit [3:0] ctl;
    bit [1:0] a, b;
  } ex_t;

  typedef struct {
    in_t i;
    ex_t e;
  } vec_t;

  typedef struct {
    bit v;
    int rd;
    bit rw, mr;
  } minstr_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Instruction-level model: older instructions ahead of ID, index 0 = in EX, 1 = MEM, 2 = WB.
  minstr_t pipe[3];
  int m_stalls = 0;
  int m_flushes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic in_t mk_in(bit v, bit [4:0] rs1, bit [4:0] rs2, bit u1, bit u2,
                                bit [4:0] rd, bit rw, bit mr, bit fl);
    in_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
    r.rd = rd; r.rw = rw; r.mr = mr; r.fl = fl;
    return r;
  endfunction

  function automatic ex_t mk_ex(bit st, bit fi, bit bu, bit [1:0] a, bit [1:0] b);
    ex_t e;
    e.ctl = {st, st, fi, bu};
    e.a = a;
    e.b = b;
    return e;
  endfunction

  // Nearest older writer of rs that will sit in MEM (2) or WB (1) when the consumer is in EX.
  function automatic bit [1:0] src_for(bit [4:0] rs, bit use_it);
    if (!use_it || rs == 0) return 2'd0;
    for (int k = 0; k < 2; k++) begin
      if (pipe[k].v && pipe[k].rw && pipe[k].rd == int'(rs))
        return (k == 0) ? 2'd2 : 2'd1;
    end
    return 2'd0;
  endfunction

  function automatic bit model_haz(in_t i);
    if (!i.v || !pipe[0].v || !pipe[0].mr || pipe[0].rd == 0) return 1'b0;
    return (i.u1 && int'(i.rs1) == pipe[0].rd) || (i.u2 && int'(i.rs2) == pipe[0].rd);
  endfunction

  function automatic ex_t model_exp(in_t i);
    bit h, st, bu;
    h  = model_haz(i);
    st = h && !i.fl;
    bu = h || i.fl;
    return mk_ex(st, i.fl, bu, bu ? 2'd0 : src_for(i.rs1, i.u1), bu ? 2'd0 : src_for(i.rs2, i.u2));
  endfunction

  task automatic model_adv(input in_t i);
    bit h;
    minstr_t n;
    h = model_haz(i);
    if (h && !i.fl) m_stalls++;
    if (i.fl) m_flushes++;
    n.v = 0; n.rd = 0; n.rw = 0; n.mr = 0;
    if (!(h || i.fl)) begin
      n.v = i.v; n.rd = int'(i.rd); n.rw = i.rw; n.mr = i.mr;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = n;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pipe[k].v = 0; pipe[k].rd = 0; pipe[k].rw = 0; pipe[k].mr = 0;
    end
    m_stalls = 0;
    m_flushes = 0;
  endtask

  task automatic drive(input in_t i);
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2;
    id_use_rs1 = i.u1; id_use_rs2 = i.u2; id_rd = i.rd;
    id_reg_write = i.rw; id_mem_read = i.mr; ex_flush = i.fl;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic run_cycle(input in_t i, input ex_t e, input string tag);
    drive(i);
    #2;
    check({tag, ".ctl"}, {28'd0, stall_pc, stall_ifid, flush_ifid, bubble_idex}, {28'd0, e.ctl});
    model_adv(i);
    @(posedge clk);
    #1;
    check({tag, ".a"}, {30'd0, fwd_a_sel}, {30'd0, e.a});
    check({tag, ".b"}, {30'd0, fwd_b_sel}, {30'd0, e.b});
    @(negedge clk);
  endtask

  vec_t tbl[$];
  in_t  nop_i;
  in_t  r;
  ex_t  e;
  bit   hold;

  initial begin
    nop_i = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // v rs1 rs2 u1 u2 rd rw mr fl | st fi bu a b
    tbl.push_back('{mk_in(1, 1, 2, 1, 1, 5, 1, 0, 0),   mk_ex(0, 0, 0, 0, 0)}); // add x5
    tbl.push_back('{mk_in(1, 5, 1, 1, 1, 6, 1, 0, 0),   mk_ex(0, 0, 0, 2, 0)}); // add x6,x5,x1
    tbl.push_back('{mk_in(1, 3, 4, 1, 1, 5, 1, 0, 0),   mk_ex(0, 0, 0, 0, 0)}); // add x5
    tbl.push_back('{nop_i,                               mk_ex(0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(1, 1, 5, 1, 1, 7, 1, 0, 0),   mk_ex(0, 0, 0, 0, 1)}); // sub x7,x1,x5
    tbl.push_back('{mk_in(1, 7, 0, 1, 1, 5, 1, 0, 0),   mk_ex(0, 0, 0, 2, 0)}); // add x5,x7,x0
    tbl.push_back('{mk_in(1, 1, 1, 1, 1, 5, 1, 0, 0),   mk_ex(0, 0, 0, 0, 0)}); // add x5
    tbl.push_back('{mk_in(1, 5, 5, 1, 1, 8, 1, 0, 0),   mk_ex(0, 0, 0, 2, 2)}); // x5 in MEM and WB
    tbl.push_back('{mk_in(1, 8, 0, 1, 0, 5, 1, 1, 0),   mk_ex(0, 0, 0, 2, 0)}); // lw x5,(x8)
    tbl.push_back('{mk_in(1, 5, 2, 1, 1, 6, 1, 0, 0),   mk_ex(1, 0, 1, 0, 0)}); // load-use stall
    tbl.push_back('{mk_in(1, 5, 2, 1, 1, 6, 1, 0, 0),   mk_ex(0, 0, 0, 1, 0)}); // replay, WB fwd
    tbl.push_back('{nop_i,                               mk_ex(0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(1, 1, 0, 1, 0, 0, 1, 1, 0),   mk_ex(0, 0, 0, 0, 0)}); // lw x0
    tbl.push_back('{mk_in(1, 0, 0, 1, 1, 9, 1, 0, 0),   mk_ex(0, 0, 0, 0, 0)}); // use x0
    tbl.push_back('{mk_in(1, 1, 0, 1, 0, 0, 1, 0, 0),   mk_ex(0, 0, 0, 0, 0)}); // addi x0
    tbl.push_back('{mk_in(1, 0, 0, 1, 1, 10, 1, 0, 0),  mk_ex(0, 0, 0, 0, 0)}); // use x0
    tbl.push_back('{mk_in(1, 1, 0, 1, 0, 11, 1, 1, 0),  mk_ex(0, 0, 0, 0, 0)}); // lw x11
    tbl.push_back('{mk_in(1, 11, 11, 1, 1, 12, 1, 0, 1), mk_ex(0, 1, 1, 0, 0)}); // flush beats hazard
    tbl.push_back('{mk_in(1, 11, 1, 1, 1, 13, 1, 0, 0), mk_ex(0, 0, 0, 1, 0)});
    tbl.push_back('{mk_in(1, 13, 13, 1, 1, 14, 1, 0, 1), mk_ex(0, 1, 1, 0, 0)}); // flush kills fwd
    tbl.push_back('{mk_in(1, 13, 1, 1, 1, 15, 1, 0, 0), mk_ex(0, 0, 0, 1, 0)});
    tbl.push_back('{mk_in(1, 15, 15, 0, 1, 16, 1, 0, 0), mk_ex(0, 0, 0, 0, 2)}); // rs1 unused
    tbl.push_back('{mk_in(1, 1, 0, 1, 0, 17, 1, 1, 0),  mk_ex(0, 0, 0, 0, 0)}); // lw x17
    tbl.push_back('{mk_in(1, 2, 17, 1, 1, 0, 0, 0, 0),  mk_ex(1, 0, 1, 0, 0)}); // store-data hazard
    tbl.push_back('{mk_in(1, 2, 17, 1, 1, 0, 0, 0, 0),  mk_ex(0, 0, 0, 0, 1)});

    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check("rst.ctl", {28'd0, stall_pc, stall_ifid, flush_ifid, bubble_idex}, 32'd0);
    check("rst.a", {30'd0, fwd_a_sel}, 32'd0);
    check("rst.b", {30'd0, fwd_b_sel}, 32'd0);
    ex_flush = 1'b1;
    #1;
    check("rst.flush_ctl", {28'd0, stall_pc, stall_ifid, flush_ifid, bubble_idex}, 32'b0011);
    ex_flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) run_cycle(tbl[k].i, tbl[k].e, $sformatf("dir%0d", k));

`ifdef HAZARD_PERF_CNT_EN
    check("perf.stall_dir", perf_stall_cnt, 32'd2);
    check("perf.flush_dir", perf_flush_cnt, 32'd2);
`endif

    // Mid-stream reset with a load-use hazard pending and a live forward select.
    r = mk_in(1, 1, 2, 1, 1, 8, 1, 0, 0);
    run_cycle(r, model_exp(r), "mr.add");
    r = mk_in(1, 8, 0, 1, 0, 5, 1, 1, 0);
    run_cycle(r, model_exp(r), "mr.lw");
    r = mk_in(1, 5, 2, 1, 1, 6, 1, 0, 0);
    drive(r);
    #2;
    check("mr.pre_ctl", {28'd0, stall_pc, stall_ifid, flush_ifid, bubble_idex}, 32'b1101);
    check("mr.pre_a", {30'd0, fwd_a_sel}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mr.rst_ctl", {28'd0, stall_pc, stall_ifid, flush_ifid, bubble_idex}, 32'd0);
    check("mr.rst_a", {30'd0, fwd_a_sel}, 32'd0);
    check("mr.rst_b", {30'd0, fwd_b_sel}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    r = mk_in(1, 1, 2, 1, 1, 5, 1, 0, 0);
    run_cycle(r, model_exp(r), "mr.post0");
    r = mk_in(1, 5, 1, 1, 1, 6, 1, 0, 0);
    e = model_exp(r);
    check("mr.post_model", {30'd0, e.a}, 32'd2);
    run_cycle(r, e, "mr.post1");

    // Randomized run; a stalled instruction is re-presented like a held IF/ID register.
    hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        r.v   = ($urandom_range(0, 7) != 0);
        r.rs1 = 5'($urandom_range(0, 7));
        r.rs2 = 5'($urandom_range(0, 7));
        r.u1  = r.v && ($urandom_range(0, 3) != 0);
        r.u2  = r.v && ($urandom_range(0, 3) != 0);
        r.rd  = 5'($urandom_range(0, 7));
        r.mr  = r.v && ($urandom_range(0, 2) == 0);
        r.rw  = r.mr || (r.v && ($urandom_range(0, 3) != 0));
      end
      r.fl = ($urandom_range(0, 9) == 0);
      e = model_exp(r);
      hold = e.ctl[3];
      run_cycle(r, e, "rnd");
    end

`ifdef HAZARD_PERF_CNT_EN
    check("perf.stall_rnd", perf_stall_cnt, m_stalls);
    check("perf.flush_rnd", perf_flush_cnt, m_flushes);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
